// File: rtl/timepulse_sequencer.sv
// Timepulse/phase sequencer: one-hot phase and timepulse strobes per memory cycle time,
// GOJAM restart window, monitor stop/single-step control and a completed-MCT counter.
module timepulse_sequencer #(
  parameter int NUM_TP     = 12,
  parameter int NUM_PHASES = 4,
  parameter int GOJAM_CYC  = 8,
  parameter int CNT_W      = 16,
  parameter int TPW        = $clog2(NUM_TP)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  strt1,
  input  logic                  stop_req,
  input  logic                  step,
  output logic                  gojam,
  output logic [NUM_PHASES-1:0] phs,
  output logic [NUM_TP-1:0]     tp,
  output logic [TPW-1:0]        tp_idx,
  output logic                  mct_done,
  output logic                  stopped,
  output logic [CNT_W-1:0]      mct_count
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int GW = $clog2(GOJAM_CYC + 1);

  localparam logic [PW-1:0]  PH_LAST = PW'(NUM_PHASES - 1);
  localparam logic [TPW-1:0] TP_LAST = TPW'(NUM_TP - 1);
  localparam logic [GW-1:0]  GJ_LOAD = GW'(GOJAM_CYC);

  typedef enum logic [1:0] {
    ST_GOJAM   = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [GW-1:0]           gj_cnt_r;
  logic [GW-1:0]           gj_cnt_s;
  logic [PW-1:0]           phase_r;
  logic [PW-1:0]           phase_s;
  logic [TPW-1:0]          tpi_r;
  logic [TPW-1:0]          tpi_s;
  logic                    step_r;
  logic                    step_edge_s;

  logic                    run_s;
  logic                    gojam_s;
  logic [NUM_PHASES-1:0]   phs_s;
  logic [NUM_TP-1:0]       tp_s;
  logic [TPW-1:0]          tp_idx_s;
  logic                    mct_done_s;
  logic                    stopped_s;

  logic                    gojam_r;
  logic [NUM_PHASES-1:0]   phs_r;
  logic [NUM_TP-1:0]       tp_r;
  logic [TPW-1:0]          tp_idx_r;
  logic                    mct_done_r;
  logic                    stopped_r;
  logic [CNT_W-1:0]        mct_count_r;

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PW-1:0] p);
    phase_onehot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << p;
  endfunction

  function automatic logic [NUM_TP-1:0] tp_onehot(input logic [TPW-1:0] t);
    tp_onehot = {{(NUM_TP-1){1'b0}}, 1'b1} << t;
  endfunction

  // Only a step edge seen while halted may resume; earlier edges are not remembered.
  assign step_edge_s = step & ~step_r;

  // Next-state logic; strt1 overrides everything else.
  always_comb begin
    state_s  = state_r;
    gj_cnt_s = gj_cnt_r;
    phase_s  = phase_r;
    tpi_s    = tpi_r;
    if (strt1) begin
      state_s  = ST_GOJAM;
      gj_cnt_s = GJ_LOAD;
      phase_s  = '0;
      tpi_s    = '0;
    end else begin
      case (state_r)
        ST_GOJAM: begin
          phase_s = '0;
          tpi_s   = '0;
          if (gj_cnt_r <= GW'(1)) begin
            state_s  = ST_RUN;
            gj_cnt_s = GJ_LOAD;
          end else begin
            gj_cnt_s = gj_cnt_r - GW'(1);
          end
        end
        ST_RUN: begin
          if (phase_r != PH_LAST) begin
            phase_s = phase_r + PW'(1);
          end else begin
            phase_s = '0;
            if (tpi_r != TP_LAST) begin
              tpi_s = tpi_r + TPW'(1);
            end else begin
              tpi_s   = '0;
              state_s = stop_req ? ST_STOPPED : ST_RUN;
            end
          end
        end
        ST_STOPPED: begin
          phase_s = '0;
          tpi_s   = '0;
          if (step_edge_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_STOPPED;
          end
        end
        default: begin
          state_s  = ST_GOJAM;
          gj_cnt_s = GJ_LOAD;
          phase_s  = '0;
          tpi_s    = '0;
        end
      endcase
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    run_s      = (state_s == ST_RUN);
    gojam_s    = (state_s == ST_GOJAM);
    stopped_s  = (state_s == ST_STOPPED);
    phs_s      = '0;
    tp_s       = '0;
    tp_idx_s   = '0;
    mct_done_s = 1'b0;
    if (run_s) begin
      phs_s      = phase_onehot(phase_s);
      tp_s       = tp_onehot(tpi_s);
      tp_idx_s   = tpi_s;
      mct_done_s = (phase_s == PH_LAST) && (tpi_s == TP_LAST);
    end else begin
      phs_s      = '0;
      tp_s       = '0;
      tp_idx_s   = '0;
      mct_done_s = 1'b0;
    end
  end

  // Sequencer state, step edge detector and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_GOJAM;
      gj_cnt_r    <= GJ_LOAD;
      phase_r     <= '0;
      tpi_r       <= '0;
      step_r      <= 1'b0;
      gojam_r     <= 1'b1;
      phs_r       <= '0;
      tp_r        <= '0;
      tp_idx_r    <= '0;
      mct_done_r  <= 1'b0;
      stopped_r   <= 1'b0;
      mct_count_r <= '0;
    end else begin
      state_r    <= state_s;
      gj_cnt_r   <= gj_cnt_s;
      phase_r    <= phase_s;
      tpi_r      <= tpi_s;
      step_r     <= step;
      gojam_r    <= gojam_s;
      phs_r      <= phs_s;
      tp_r       <= tp_s;
      tp_idx_r   <= tp_idx_s;
      mct_done_r <= mct_done_s;
      stopped_r  <= stopped_s;
      // A finished MCT counts even when strt1 arrives on the same edge.
      if (mct_done_r) begin
        mct_count_r <= mct_count_r + CNT_W'(1);
      end else begin
        mct_count_r <= mct_count_r;
      end
    end
  end

  assign gojam     = gojam_r;
  assign phs       = phs_r;
  assign tp        = tp_r;
  assign tp_idx    = tp_idx_r;
  assign mct_done  = mct_done_r;
  assign stopped   = stopped_r;
  assign mct_count = mct_count_r;

endmodule

// File: tb/tb_timepulse_sequencer.sv
// Bench for timepulse_sequencer: table of input segments with checkpoint values, a
// position-based reference model feeding a scoreboard queue, and a small-parameter instance.
module tb_timepulse_sequencer;

  localparam int NTP = 12;
  localparam int NPH = 4;
  localparam int L   = NTP * NPH;
  localparam int GJ  = 8;

  logic        clock = 1'b0;
  logic        rst_n, strt1, stop_req, step;
  logic        gojam, mct_done, stopped;
  logic [3:0]  phs;
  logic [11:0] tp;
  logic [3:0]  tp_idx;
  logic [15:0] mct_count;

  logic        rst_b, strt1_b, stop_b, step_b;
  logic        gojam_b, mct_done_b, stopped_b;
  logic [1:0]  phs_b;
  logic [2:0]  tp_b;
  logic [1:0]  tp_idx_b;
  logic [3:0]  mct_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  timepulse_sequencer dut (
    .clock(clock), .rst_n(rst_n), .strt1(strt1), .stop_req(stop_req), .step(step),
    .gojam(gojam), .phs(phs), .tp(tp), .tp_idx(tp_idx), .mct_done(mct_done),
    .stopped(stopped), .mct_count(mct_count)
  );

  timepulse_sequencer #(.NUM_TP(3), .NUM_PHASES(2), .GOJAM_CYC(8), .CNT_W(4)) dut_b (
    .clock(clock), .rst_n(rst_b), .strt1(strt1_b), .stop_req(stop_b), .step(step_b),
    .gojam(gojam_b), .phs(phs_b), .tp(tp_b), .tp_idx(tp_idx_b), .mct_done(mct_done_b),
    .stopped(stopped_b), .mct_count(mct_count_b)
  );

  typedef struct {
    logic        gojam;
    logic [3:0]  phs;
    logic [11:0] tp;
    logic [3:0]  idx;
    logic        done;
    logic        stopped;
    logic [15:0] count;
  } exp_t;

  typedef struct {
    string name;
    int    cycles;
    logic  strt1;
    logic  stop_req;
    logic  step;
    logic  exp_gojam;
    logic  exp_stopped;
    int    exp_count;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  // Reference model: mode 0=GOJAM 1=RUN 2=STOPPED, position within the MCT.
  int m_mode, m_gj, m_pos, m_count;
  bit m_prev_step;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_gj = GJ; m_pos = 0; m_count = 0; m_prev_step = 1'b0;
  endtask

  task automatic model_step(input logic s1, input logic sr, input logic st);
    bit done, edge_s;
    done   = (m_mode == 1) && (m_pos == L - 1);
    edge_s = st && !m_prev_step;
    m_prev_step = st;
    if (done) m_count = (m_count + 1) % 65536;
    if (s1) begin
      m_mode = 0; m_gj = GJ; m_pos = 0;
    end else if (m_mode == 0) begin
      m_gj--;
      if (m_gj == 0) begin m_mode = 1; m_pos = 0; end
    end else if (m_mode == 1) begin
      if (done) begin
        m_pos = 0;
        if (sr) m_mode = 2;
      end else begin
        m_pos++;
      end
    end else begin
      if (edge_s) begin m_mode = 1; m_pos = 0; end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit run;
    run       = (m_mode == 1);
    e.gojam   = (m_mode == 0);
    e.stopped = (m_mode == 2);
    e.tp      = run ? (12'd1 << (m_pos / NPH)) : 12'd0;
    e.phs     = run ? (4'd1 << (m_pos % NPH)) : 4'd0;
    e.idx     = run ? 4'(m_pos / NPH) : 4'd0;
    e.done    = run && (m_pos == L - 1);
    e.stopped = (m_mode == 2);
    e.count   = 16'(m_count);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    model_step(strt1, stop_req, step);
    sb_q.push_back(model_out());
    @(posedge clock);
    @(negedge clock);
    e = sb_q.pop_front();
    chk("gojam", 32'(gojam), 32'(e.gojam));
    chk("phs", 32'(phs), 32'(e.phs));
    chk("tp", 32'(tp), 32'(e.tp));
    chk("tp_idx", 32'(tp_idx), 32'(e.idx));
    chk("mct_done", 32'(mct_done), 32'(e.done));
    chk("stopped", 32'(stopped), 32'(e.stopped));
    chk("mct_count", 32'(mct_count), 32'(e.count));
  endtask

  task automatic apply_vec(input vec_t v);
    strt1    = v.strt1;
    stop_req = v.stop_req;
    step     = v.step;
    repeat (v.cycles) tick();
    chk({v.name, ".gojam"}, 32'(gojam), 32'(v.exp_gojam));
    chk({v.name, ".stopped"}, 32'(stopped), 32'(v.exp_stopped));
    chk({v.name, ".count"}, 32'(mct_count), 32'(v.exp_count));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".gojam"}, 32'(gojam), 32'd1);
    chk({nm, ".phs"}, 32'(phs), 32'd0);
    chk({nm, ".tp"}, 32'(tp), 32'd0);
    chk({nm, ".tp_idx"}, 32'(tp_idx), 32'd0);
    chk({nm, ".mct_done"}, 32'(mct_done), 32'd0);
    chk({nm, ".stopped"}, 32'(stopped), 32'd0);
    chk({nm, ".mct_count"}, 32'(mct_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; strt1 = 1'b0; stop_req = 1'b0; step = 1'b0;
    rst_b = 1'b0; strt1_b = 1'b0; stop_b = 1'b0; step_b = 1'b0;

    //          name            cyc  strt1 stop  step  gojam stopped count
    vecs.push_back('{"release",      8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"first_mct",   48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"to_t6",       20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"stop_mid",    28, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{"hold_stop",  100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{"step1",        1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{"run_a",       10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{"step_in_run",  3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{"run_b",       34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{"end_single",   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3});
    vecs.push_back('{"no_queue",    20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3});
    vecs.push_back('{"resume",       1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3});
    vecs.push_back('{"to_t6p2",     22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{"strt1_pulse",  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{"gojam_wait",   7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{"back_t01",     1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{"to_done",     47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{"strt1_done",   1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4});
    vecs.push_back('{"restart",      8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{"run_stop",    48, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5});
    vecs.push_back('{"strt1_stop",   3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5});
    vecs.push_back('{"restart2",     8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{"mid_mct",     30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5});

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Asynchronous reset mid-MCT, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clock);
    @(negedge clock);
    model_reset();
    rst_n = 1'b1;
    apply_vec(vecs[0]);
    apply_vec(vecs[1]);

    // Small instance: 3 timepulses x 2 phases, 4-bit counter wrap.
    @(negedge clock);
    rst_b = 1'b1;
    for (int j = 1; j <= 8 + 96; j++) begin
      @(posedge clock);
      @(negedge clock);
      if (j < 8) begin
        chk("b.gojam_win", 32'(gojam_b), 32'd1);
      end else begin
        r = j - 8;
        chk("b.gojam", 32'(gojam_b), 32'd0);
        chk("b.mct_done", 32'(mct_done_b), (r % 6 == 5) ? 32'd1 : 32'd0);
        chk("b.mct_count", 32'(mct_count_b), 32'((r / 6) % 16));
        chk("b.tp", 32'(tp_b), 32'd1 << ((r % 6) / 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
